// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - segment bit positions and hex glyph constants shared by the scan controller
package seg7_pkg;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  localparam logic [7:0] SEG_OFF = 8'h00;

  // {g,f,e,d,c,b,a}, segment on = 1
  localparam logic [6:0] GLYPH_0 = 7'h3F;
  localparam logic [6:0] GLYPH_1 = 7'h06;
  localparam logic [6:0] GLYPH_2 = 7'h5B;
  localparam logic [6:0] GLYPH_3 = 7'h4F;
  localparam logic [6:0] GLYPH_4 = 7'h66;
  localparam logic [6:0] GLYPH_5 = 7'h6D;
  localparam logic [6:0] GLYPH_6 = 7'h7D;
  localparam logic [6:0] GLYPH_7 = 7'h07;
  localparam logic [6:0] GLYPH_8 = 7'h7F;
  localparam logic [6:0] GLYPH_9 = 7'h6F;
  localparam logic [6:0] GLYPH_A = 7'h77;
  localparam logic [6:0] GLYPH_B = 7'h7C;
  localparam logic [6:0] GLYPH_C = 7'h39;
  localparam logic [6:0] GLYPH_D = 7'h5E;
  localparam logic [6:0] GLYPH_E = 7'h79;
  localparam logic [6:0] GLYPH_F = 7'h71;

endpackage

// File: rtl/seg7_hex_decode.sv
// rtl/seg7_hex_decode.sv - combinational hex nibble to 7-segment glyph
import seg7_pkg::*;

module seg7_hex_decode (
  input  logic [3:0] i_nibble,
  output logic [6:0] o_glyph
);

  always_comb begin
    o_glyph = GLYPH_0;
    case (i_nibble)
      4'h0: o_glyph = GLYPH_0;
      4'h1: o_glyph = GLYPH_1;
      4'h2: o_glyph = GLYPH_2;
      4'h3: o_glyph = GLYPH_3;
      4'h4: o_glyph = GLYPH_4;
      4'h5: o_glyph = GLYPH_5;
      4'h6: o_glyph = GLYPH_6;
      4'h7: o_glyph = GLYPH_7;
      4'h8: o_glyph = GLYPH_8;
      4'h9: o_glyph = GLYPH_9;
      4'hA: o_glyph = GLYPH_A;
      4'hB: o_glyph = GLYPH_B;
      4'hC: o_glyph = GLYPH_C;
      4'hD: o_glyph = GLYPH_D;
      4'hE: o_glyph = GLYPH_E;
      default: o_glyph = GLYPH_F;
    endcase
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// rtl/seg7_scan_ctrl.sv - time-multiplexed 7-segment scan with blink, blanking, LZS and dead time
import seg7_pkg::*;

module seg7_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 25000,
  parameter int DEAD_CYCLES  = 500,
  parameter int BLINK_FRAMES = 128,
  parameter int ACTIVE_LOW   = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable_i,
  input  logic [4*NUM_DIGITS-1:0] digits_i,
  input  logic [NUM_DIGITS-1:0]   dp_i,
  input  logic [NUM_DIGITS-1:0]   blink_i,
  input  logic [NUM_DIGITS-1:0]   blank_i,
  input  logic                    lzs_i,
  output logic [7:0]              seg_o,
  output logic [NUM_DIGITS-1:0]   an_o,
  output logic                    frame_o
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic POL = (ACTIVE_LOW != 0);
  localparam logic [7:0]            SEG_IDLE = SEG_OFF ^ {8{POL}};
  localparam logic [NUM_DIGITS-1:0] AN_IDLE  = {NUM_DIGITS{POL}};

  logic [PW-1:0]           r_presc;
  logic [IW-1:0]           r_idx;
  logic [FW-1:0]           r_fcnt;
  logic                    r_phase;
  logic [4*NUM_DIGITS-1:0] r_sh_digits;
  logic [NUM_DIGITS-1:0]   r_sh_dp;
  logic [NUM_DIGITS-1:0]   r_sh_blink;
  logic [NUM_DIGITS-1:0]   r_sh_blank;
  logic                    r_sh_lzs;
  logic [7:0]              r_seg;
  logic [NUM_DIGITS-1:0]   r_an;
  logic                    r_frame;

  logic                    w_tick;
  logic                    w_last;
  logic                    w_frame_start;
  logic                    w_dead;
  logic                    w_upper_zero;
  logic                    w_dark;
  logic [3:0]              w_nibble;
  logic [6:0]              w_glyph;
  logic [7:0]              w_seg;

  assign w_tick        = enable_i && (r_presc == PW'(SCAN_DIV - 1));
  assign w_last        = (r_idx == IW'(NUM_DIGITS - 1));
  assign w_frame_start = w_tick && w_last;
  assign w_dead        = (DEAD_CYCLES > 0) && (int'(r_presc) < DEAD_CYCLES);
  assign w_nibble      = r_sh_digits[4*int'(r_idx) +: 4];

  // Suppress when this digit and everything to its left are zero
  always_comb begin
    w_upper_zero = 1'b1;
    for (int j = 0; j < NUM_DIGITS; j++) begin
      if (j >= int'(r_idx) && r_sh_digits[4*j +: 4] != 4'h0) begin
        w_upper_zero = 1'b0;
      end
    end
  end

  assign w_dark = r_sh_blank[r_idx]
               || (r_sh_blink[r_idx] && r_phase)
               || (r_sh_lzs && (r_idx != '0) && w_upper_zero);

  seg7_hex_decode u_decode (
    .i_nibble (w_nibble),
    .o_glyph  (w_glyph)
  );

  always_comb begin
    w_seg               = SEG_OFF;
    w_seg[SEG_G:SEG_A]  = w_glyph;
    w_seg[SEG_DP]       = r_sh_dp[r_idx];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_presc     <= '0;
      r_idx       <= '0;
      r_fcnt      <= '0;
      r_phase     <= 1'b0;
      r_sh_digits <= '0;
      r_sh_dp     <= '0;
      r_sh_blink  <= '0;
      r_sh_blank  <= '0;
      r_sh_lzs    <= 1'b0;
    end else if (enable_i) begin
      r_presc <= w_tick ? '0 : r_presc + 1'b1;
      if (w_tick) begin
        r_idx <= w_last ? '0 : r_idx + 1'b1;
      end
      if (w_frame_start) begin
        r_sh_digits <= digits_i;
        r_sh_dp     <= dp_i;
        r_sh_blink  <= blink_i;
        r_sh_blank  <= blank_i;
        r_sh_lzs    <= lzs_i;
        if (r_fcnt == FW'(BLINK_FRAMES - 1)) begin
          r_fcnt  <= '0;
          r_phase <= ~r_phase;
        end else begin
          r_fcnt <= r_fcnt + 1'b1;
        end
      end
    end
  end

  // Pin polarity is folded into the register so the pins stay glitch-free
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_seg   <= SEG_IDLE;
      r_an    <= AN_IDLE;
      r_frame <= 1'b0;
    end else begin
      r_frame <= w_frame_start;
      if (!enable_i || w_dead || w_dark) begin
        r_seg <= SEG_IDLE;
        r_an  <= AN_IDLE;
      end else begin
        r_seg <= w_seg ^ {8{POL}};
        r_an  <= (NUM_DIGITS'(1) << r_idx) ^ AN_IDLE;
      end
    end
  end

  assign seg_o   = r_seg;
  assign an_o    = r_an;
  assign frame_o = r_frame;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb/tb_seg7_scan_ctrl.sv - scoreboard bench for seg7_scan_ctrl
module tb_seg7_scan_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable_i = 1'b1;
  logic [15:0] digits_i = 16'h1234;
  logic [3:0]  dp_i = 4'b0000;
  logic [3:0]  blink_i = 4'b0000;
  logic [3:0]  blank_i = 4'b0000;
  logic        lzs_i = 1'b0;
  logic [7:0]  seg_o;
  logic [3:0]  an_o;
  logic        frame_o;

  int n_cmp = 0;
  int n_bad = 0;
  logic [11:0] q[$];
  int  exp_period = 32;
  bit  chk_run = 1'b1;

  always #5 clk = ~clk;

  seg7_scan_ctrl #(
    .NUM_DIGITS   (4),
    .SCAN_DIV     (8),
    .DEAD_CYCLES  (2),
    .BLINK_FRAMES (2),
    .ACTIVE_LOW   (0)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .enable_i (enable_i),
    .digits_i (digits_i),
    .dp_i     (dp_i),
    .blink_i  (blink_i),
    .blank_i  (blank_i),
    .lzs_i    (lzs_i),
    .seg_o    (seg_o),
    .an_o     (an_o),
    .frame_o  (frame_o)
  );

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push(input logic [3:0] an, input logic [7:0] seg);
    q.push_back({an, seg});
  endtask

  task automatic push4(input logic [7:0] s0, input logic [7:0] s1,
                       input logic [7:0] s2, input logic [7:0] s3);
    push(4'b0001, s0);
    push(4'b0010, s1);
    push(4'b0100, s2);
    push(4'b1000, s3);
  endtask

  task automatic wait_frame();
    int k;
    @(negedge clk);
    k = 1;
    while (!frame_o && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!frame_o) begin
      n_cmp++;
      n_bad++;
      $display("FAIL frame_timeout: no frame_o within %0d cycles", k);
    end
  endtask

  // Monitor: pops one expected entry every time a new digit lights up
  initial begin
    logic [3:0]  prev_an;
    logic [11:0] e;
    int run, cyc, last_cyc;
    bit last_valid;
    prev_an = '0; run = 0; cyc = 0; last_cyc = 0; last_valid = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (!reset) begin
        prev_an = '0;
        run = 0;
        last_valid = 1'b0;
      end else begin
        if (an_o == 4'b0000) check("dark_seg", int'(seg_o), 0);
        if (an_o != prev_an) begin
          if (prev_an != 4'b0000 && chk_run) check("run_len", run, 6);
          if (an_o != 4'b0000) begin
            if (q.size() == 0) begin
              n_cmp++;
              n_bad++;
              $display("FAIL unexpected_digit: got an=%b seg=%h expected nothing", an_o, seg_o);
            end else begin
              e = q.pop_front();
              check("slot_an", int'(an_o), int'(e[11:8]));
              check("slot_seg", int'(seg_o), int'(e[7:0]));
            end
          end
          run = 1;
        end else begin
          run++;
        end
        prev_an = an_o;
        if (frame_o) begin
          if (last_valid && exp_period != 0) check("frame_period", cyc - last_cyc, exp_period);
          last_valid = 1'b1;
          last_cyc = cyc;
        end
      end
    end
  end

  initial begin
    #12;
    check("rst_an", int'(an_o), 0);
    check("rst_seg", int'(seg_o), 0);
    check("rst_frame", int'(frame_o), 0);
    push4(8'h3F, 8'h3F, 8'h3F, 8'h3F);
    @(negedge clk);
    reset = 1'b1;

    wait_frame();                       // f1: 1234
    push4(8'h66, 8'h4F, 8'h5B, 8'h06);
    blink_i = 4'b0100;
    wait_frame();                       // f2: phase 1
    push(4'b0001, 8'h66); push(4'b0010, 8'h4F); push(4'b1000, 8'h06);
    wait_frame();                       // f3: phase 1
    push(4'b0001, 8'h66); push(4'b0010, 8'h4F); push(4'b1000, 8'h06);
    wait_frame();                       // f4: phase 0
    push4(8'h66, 8'h4F, 8'h5B, 8'h06);
    wait_frame();                       // f5: phase 0
    push4(8'h66, 8'h4F, 8'h5B, 8'h06);
    wait_frame();                       // f6: phase 1
    push(4'b0001, 8'h66); push(4'b0010, 8'h4F); push(4'b1000, 8'h06);
    blink_i = 4'b0000; lzs_i = 1'b1; digits_i = 16'h0070;
    wait_frame();                       // f7: LZS 0070
    push(4'b0001, 8'h3F); push(4'b0010, 8'h07);
    digits_i = 16'h0000;
    wait_frame();                       // f8: LZS 0000
    push(4'b0001, 8'h3F);
    lzs_i = 1'b0; digits_i = 16'h1111;
    wait_frame();                       // f9: 1111, changed mid-frame
    push4(8'h06, 8'h06, 8'h06, 8'h06);
    repeat (12) @(negedge clk);
    digits_i = 16'h2222;
    wait_frame();                       // f10: 2222
    push4(8'h5B, 8'h5B, 8'h5B, 8'h5B);
    dp_i = 4'b0001; blank_i = 4'b0010;
    wait_frame();                       // f11: dp on 0, digit 1 blanked
    push(4'b0001, 8'hDB); push(4'b0100, 8'h5B); push(4'b1000, 8'h5B);
    dp_i = 4'b0000; blank_i = 4'b0000; digits_i = 16'h1234;
    wait_frame();                       // f12: enable low mid-slot 1
    chk_run = 1'b0;
    exp_period = 52;
    push(4'b0001, 8'h66); push(4'b0010, 8'h4F); push(4'b0010, 8'h4F);
    push(4'b0100, 8'h5B); push(4'b1000, 8'h06);
    repeat (12) @(negedge clk);
    enable_i = 1'b0;
    repeat (20) @(negedge clk);
    enable_i = 1'b1;
    wait_frame();                       // f13
    chk_run = 1'b1;
    exp_period = 32;
    push4(8'h66, 8'h4F, 8'h5B, 8'h06);
    wait_frame();                       // f14: async reset during slot 1
    push(4'b0001, 8'h66); push(4'b0010, 8'h4F);
    repeat (13) @(negedge clk);
    #1 reset = 1'b0;
    #1;
    check("async_an", int'(an_o), 0);
    check("async_seg", int'(seg_o), 0);
    check("async_frame", int'(frame_o), 0);
    repeat (3) @(negedge clk);
    push4(8'h3F, 8'h3F, 8'h3F, 8'h3F);
    reset = 1'b1;
    wait_frame();                       // first frame after reset release
    push4(8'h66, 8'h4F, 8'h5B, 8'h06);
    wait_frame();
    enable_i = 1'b0;
    repeat (5) @(negedge clk);
    check("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1);
  end

endmodule
